// File: rtl/cmip_pluse_sched.sv
// cmip_pluse_sched: multi-channel trigger-to-pulse scheduler.
// A synchronized trigger edge latches a shadow config snapshot and runs one
// shared timebase; each channel pulses for hold cycles starting dly cycles in.
module cmip_pluse_sched #(
  parameter int CH_NUM  = 4,
  parameter int DLY_WD  = 16,
  parameter int HOLD_WD = 8,
  parameter int CH_WD   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_trig,
  input  logic               i_cfg_we,
  input  logic [CH_WD-1:0]   i_cfg_ch,
  input  logic [DLY_WD-1:0]  i_cfg_dly,
  input  logic [HOLD_WD-1:0] i_cfg_hold,
  output logic [CH_NUM-1:0]  o_pluse,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_trig_miss
);

  // One extra bit so dly + hold never wraps.
  localparam int END_WD = DLY_WD + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                trig_d1_q, trig_d2_q;
  logic                trig_pos;
  logic [END_WD-1:0]   tcnt_q, tcnt_d;
  logic [END_WD-1:0]   max_end_q, max_end_d;
  logic [CH_NUM-1:0]   pluse_q, pluse_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                miss_q, miss_d;

  logic [DLY_WD-1:0]   shadow_dly_q  [CH_NUM];
  logic [DLY_WD-1:0]   shadow_dly_d  [CH_NUM];
  logic [HOLD_WD-1:0]  shadow_hold_q [CH_NUM];
  logic [HOLD_WD-1:0]  shadow_hold_d [CH_NUM];
  logic [DLY_WD-1:0]   act_dly_q     [CH_NUM];
  logic [DLY_WD-1:0]   act_dly_d     [CH_NUM];
  logic [HOLD_WD-1:0]  act_hold_q    [CH_NUM];
  logic [HOLD_WD-1:0]  act_hold_d    [CH_NUM];
  logic [END_WD-1:0]   act_end_q     [CH_NUM];
  logic [END_WD-1:0]   act_end_d     [CH_NUM];

  logic [END_WD-1:0]   shadow_end    [CH_NUM];
  logic [END_WD-1:0]   shadow_max;
  logic [CH_NUM-1:0]   pluse_act;

  assign trig_pos = trig_d1_q & ~trig_d2_q;

  // End time of each shadow entry; disabled channels contribute 0 so an
  // all-disabled config yields max_end of 0.
  always_comb begin
    shadow_max = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (shadow_hold_q[c] != '0) begin
        shadow_end[c] = {1'b0, shadow_dly_q[c]} + END_WD'(shadow_hold_q[c]);
      end else begin
        shadow_end[c] = '0;
      end
      if (shadow_end[c] > shadow_max) begin
        shadow_max = shadow_end[c];
      end
    end
  end

  // Per-channel window test against the shared timebase.
  always_comb begin
    pluse_act = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      pluse_act[c] = (act_hold_q[c] != '0) &&
                     ({1'b0, act_dly_q[c]} <= tcnt_q) &&
                     (tcnt_q < act_end_q[c]);
    end
  end

  // Next-state logic: shadow writes, FSM, timebase and registered outputs.
  always_comb begin
    shadow_dly_d  = shadow_dly_q;
    shadow_hold_d = shadow_hold_q;
    act_dly_d     = act_dly_q;
    act_hold_d    = act_hold_q;
    act_end_d     = act_end_q;
    max_end_d     = max_end_q;
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    pluse_d       = '0;
    miss_d        = 1'b0;
    done_d        = (state_q == ST_DONE);

    for (int c = 0; c < CH_NUM; c++) begin
      if (i_cfg_we && (i_cfg_ch == CH_WD'(c))) begin
        shadow_dly_d[c]  = i_cfg_dly;
        shadow_hold_d[c] = i_cfg_hold;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (trig_pos && i_enable) begin
          act_dly_d  = shadow_dly_q;
          act_hold_d = shadow_hold_q;
          act_end_d  = shadow_end;
          max_end_d  = shadow_max;
          tcnt_d     = '0;
          state_d    = (shadow_max != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        miss_d = trig_pos;
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else begin
          tcnt_d  = tcnt_q + END_WD'(1);
          pluse_d = pluse_act;
          if (tcnt_q == max_end_q - END_WD'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        miss_d  = trig_pos;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears config and kills pulses at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      trig_d1_q <= 1'b0;
      trig_d2_q <= 1'b0;
      tcnt_q    <= '0;
      max_end_q <= '0;
      pluse_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      miss_q    <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        shadow_dly_q[c]  <= '0;
        shadow_hold_q[c] <= '0;
        act_dly_q[c]     <= '0;
        act_hold_q[c]    <= '0;
        act_end_q[c]     <= '0;
      end
    end else begin
      state_q       <= state_d;
      trig_d1_q     <= i_trig;
      trig_d2_q     <= trig_d1_q;
      tcnt_q        <= tcnt_d;
      max_end_q     <= max_end_d;
      pluse_q       <= pluse_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      miss_q        <= miss_d;
      shadow_dly_q  <= shadow_dly_d;
      shadow_hold_q <= shadow_hold_d;
      act_dly_q     <= act_dly_d;
      act_hold_q    <= act_hold_d;
      act_end_q     <= act_end_d;
    end
  end

  assign o_pluse     = pluse_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_trig_miss = miss_q;

endmodule

// File: tb/tb_cmip_pluse_sched.sv
// Directed bench for cmip_pluse_sched. Three channels are built so that
// channel index 3 is an out-of-range write target.
module tb_cmip_pluse_sched;

  localparam int NCH = 3;

  logic        clock;
  logic        rst;
  logic        enable;
  logic        trig;
  logic        cfgWe;
  logic [1:0]  cfgCh;
  logic [15:0] cfgDly;
  logic [7:0]  cfgHold;
  logic [2:0]  pluse;
  logic        busy;
  logic        done;
  logic        trigMiss;

  int totalChecks;
  int badChecks;
  int k;

  // Reference copy of what the scheduler should hold: shadow and active config.
  int modelDly  [NCH];
  int modelHold [NCH];
  int actDly    [NCH];
  int actHold   [NCH];
  int maxEnd;

  cmip_pluse_sched #(
    .CH_NUM  (NCH),
    .DLY_WD  (16),
    .HOLD_WD (8)
  ) dut (
    .i_clk       (clock),
    .i_rst       (rst),
    .i_enable    (enable),
    .i_trig      (trig),
    .i_cfg_we    (cfgWe),
    .i_cfg_ch    (cfgCh),
    .i_cfg_dly   (cfgDly),
    .i_cfg_hold  (cfgHold),
    .o_pluse     (pluse),
    .o_busy      (busy),
    .o_done      (done),
    .o_trig_miss (trigMiss)
  );

  // Free-running 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
    k++;
  endtask

  // One config write cycle; the model only records in-range channels.
  task automatic applyStimulus(input int ch, input int dly, input int hold);
    cfgWe   = 1'b1;
    cfgCh   = 2'(ch);
    cfgDly  = 16'(dly);
    cfgHold = 8'(hold);
    stepCycle();
    cfgWe = 1'b0;
    if (ch < NCH) begin
      modelDly[ch]  = dly;
      modelHold[ch] = hold;
    end
  endtask

  // Produces a clean rising edge and returns just after the accept edge E (k=0).
  task automatic fireTrigger();
    trig = 1'b0;
    repeat (3) stepCycle();
    trig = 1'b1;
    stepCycle();
    stepCycle();
    k = 0;
    if (enable) begin
      maxEnd = 0;
      for (int c = 0; c < NCH; c++) begin
        actDly[c]  = modelDly[c];
        actHold[c] = modelHold[c];
        if (modelHold[c] != 0 && modelDly[c] + modelHold[c] > maxEnd)
          maxEnd = modelDly[c] + modelHold[c];
      end
    end
  endtask

  function automatic logic [2:0] expPluse(input int kk);
    logic [2:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++)
      r[c] = (actHold[c] != 0) && (kk >= actDly[c] + 1) && (kk <= actDly[c] + actHold[c]);
    return r;
  endfunction

  task automatic checkCycle(input logic expMiss);
    checkOutput($sformatf("pluse k=%0d", k), 32'(pluse), 32'(expPluse(k)));
    checkOutput($sformatf("busy k=%0d", k), 32'(busy), 32'(k <= maxEnd));
    checkOutput($sformatf("done k=%0d", k), 32'(done), 32'(k == maxEnd + 1));
    checkOutput($sformatf("miss k=%0d", k), 32'(trigMiss), 32'(expMiss));
  endtask

  task automatic clearModel();
    for (int c = 0; c < NCH; c++) begin
      modelDly[c]  = 0;
      modelHold[c] = 0;
    end
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    k           = 0;
    maxEnd      = 0;
    clearModel();
    for (int c = 0; c < NCH; c++) begin
      actDly[c]  = 0;
      actHold[c] = 0;
    end
    rst     = 1'b1;
    enable  = 1'b1;
    trig    = 1'b0;
    cfgWe   = 1'b0;
    cfgCh   = '0;
    cfgDly  = '0;
    cfgHold = '0;

    repeat (3) stepCycle();
    checkOutput("reset pluse", 32'(pluse), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset miss", 32'(trigMiss), 32'h0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] basic sequence");
    applyStimulus(0, 5, 3);
    applyStimulus(1, 0, 2);
    fireTrigger();
    checkCycle(1'b0);
    for (int i = 1; i <= 10; i++) begin
      stepCycle();
      checkCycle(1'b0);
    end

    $display("[TB] shadow isolation and trigger while busy");
    fireTrigger();
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        cfgWe = 1'b1; cfgCh = 2'd0; cfgDly = 16'd1; cfgHold = 8'd3;
        modelDly[0] = 1; modelHold[0] = 3;
      end
      if (i == 4) trig = 1'b0;
      if (i == 5) trig = 1'b1;
      stepCycle();
      cfgWe = 1'b0;
      checkCycle(k == 6);
    end
    fireTrigger();
    for (int i = 1; i <= 6; i++) begin
      stepCycle();
      checkCycle(1'b0);
    end

    $display("[TB] all channels disabled");
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    fireTrigger();
    checkCycle(1'b0);
    for (int i = 1; i <= 3; i++) begin
      stepCycle();
      checkCycle(1'b0);
    end

    $display("[TB] abort");
    applyStimulus(0, 2, 10);
    fireTrigger();
    for (int i = 1; i <= 3; i++) begin
      stepCycle();
      checkCycle(1'b0);
    end
    enable = 1'b0;
    for (int i = 4; i <= 14; i++) begin
      stepCycle();
      checkOutput($sformatf("abort pluse k=%0d", k), 32'(pluse), 32'h0);
      checkOutput($sformatf("abort busy k=%0d", k), 32'(busy), 32'h0);
      checkOutput($sformatf("abort done k=%0d", k), 32'(done), 32'h0);
    end

    $display("[TB] trigger with enable low");
    fireTrigger();
    for (int i = 0; i <= 4; i++) begin
      checkOutput($sformatf("dis busy k=%0d", k), 32'(busy), 32'h0);
      checkOutput($sformatf("dis miss k=%0d", k), 32'(trigMiss), 32'h0);
      checkOutput($sformatf("dis pluse k=%0d", k), 32'(pluse), 32'h0);
      stepCycle();
    end
    enable = 1'b1;

    $display("[TB] reset mid-pulse");
    fireTrigger();
    for (int i = 1; i <= 4; i++) begin
      stepCycle();
      checkCycle(1'b0);
    end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async rst pluse", 32'(pluse), 32'h0);
    checkOutput("async rst busy", 32'(busy), 32'h0);
    checkOutput("async rst done", 32'(done), 32'h0);
    stepCycle();
    rst = 1'b0;
    clearModel();
    fireTrigger();
    checkCycle(1'b0);
    for (int i = 1; i <= 2; i++) begin
      stepCycle();
      checkCycle(1'b0);
    end

    $display("[TB] boundary values");
    applyStimulus(2, 65535, 255);
    applyStimulus(3, 0, 1);
    fireTrigger();
    checkOutput("bnd maxEnd model", 32'(maxEnd), 32'd65790);
    checkCycle(1'b0);
    for (int i = 1; i <= 65794; i++) begin
      stepCycle();
      if (k == 1 || k == 2 || k == 65535 || k == 65536 || k == 65664 ||
          k == 65790 || k == 65791 || k == 65792)
        checkCycle(1'b0);
    end

    $display("[TB] test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
